// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: the FSM state type and the parity modes.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    localparam int PARITY_NONE      = 0;
    localparam int PARITY_ODD       = 1;
    localparam int PARITY_EVEN      = 2;
    localparam int MIN_CLKS_PER_BIT = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so that idle-high lines come out of reset as idle.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-bit validation, optional parity, 1 or 2 stop bits,
// break recovery and a one-entry valid/ready holding register with overrun reporting.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int CLK_HZ    = 1_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (CPB < MIN_CLKS_PER_BIT) begin : g_bad_cpb
        $error("uart_rx_param: CLK_HZ/BAUD must be at least 8");
    end

    logic rx_s;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_out_q, perr_out_d;
    logic                  ferr_out_q, ferr_out_d;
    logic                  ovr_q, ovr_d;
    logic                  sample;
    logic                  commit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;
        commit     = 1'b0;
        sample     = (cnt_q == '0);

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    perr_d  = (((^shreg_q) ^ rx_s) != (PARITY == PARITY_ODD));
                    cnt_d   = CNT_FULL;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!sample) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ferr_d = ferr_q | ~rx_s;
                    cnt_d  = CNT_FULL;
                    if (idx_q == LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = ferr_d ? ST_BREAK : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word being accepted this cycle frees the holding register for the new frame.
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d     = shreg_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_d;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1 default, 8E1 and 7N2 instances driven with hand-built frames.
module tb_uart_rx_param;

    localparam int CPB = 1_000_000 / 9600;
    localparam int DEF = 0;
    localparam int PAR = 1;
    localparam int U7  = 2;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk, rst;
    logic rx_def, rx_par, rx_7;
    logic rdy_def, rdy_par, rdy_7;
    logic [7:0] def_data, par_data;
    logic [6:0] d7_data;
    logic def_valid, par_valid, v7_valid;
    logic def_perr, par_perr, p7_perr;
    logic def_ferr, par_ferr, f7_ferr;
    logic def_ovr, par_ovr, o7_ovr;
    logic def_busy, par_busy, b7_busy;

    exp_t q_def[$];
    exp_t q_par[$];
    exp_t q_7[$];
    exp_t e_def, e_par, e_7;

    int n_cmp = 0;
    int n_bad = 0;
    int del_def = 0;
    int ovr_def = 0;
    int ovr_other = 0;

    uart_rx_param u_def (
        .clk(clk), .rst(rst), .rx(rx_def), .rx_data(def_data), .rx_valid(def_valid),
        .rx_ready(rdy_def), .parity_err(def_perr), .frame_err(def_ferr), .overrun(def_ovr), .busy(def_busy)
    );

    uart_rx_param #(.PARITY(2)) u_par (
        .clk(clk), .rst(rst), .rx(rx_par), .rx_data(par_data), .rx_valid(par_valid),
        .rx_ready(rdy_par), .parity_err(par_perr), .frame_err(par_ferr), .overrun(par_ovr), .busy(par_busy)
    );

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_7b2 (
        .clk(clk), .rst(rst), .rx(rx_7), .rx_data(d7_data), .rx_valid(v7_valid),
        .rx_ready(rdy_7), .parity_err(p7_perr), .frame_err(f7_ferr), .overrun(o7_ovr), .busy(b7_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            DEF:     rx_def = v;
            PAR:     rx_par = v;
            default: rx_7   = v;
        endcase
    endtask

    task automatic push(input int which, input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        case (which)
            DEF:     q_def.push_back(e);
            PAR:     q_par.push_back(e);
            default: q_7.push_back(e);
        endcase
    endtask

    // Line ends at the last stop-bit level; stop_vals[0] is the first stop bit.
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic [1:0] stop_vals);
        set_line(which, 1'b0);
        cyc(CPB);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, data[i]);
            cyc(CPB);
        end
        if (has_par) begin
            set_line(which, par_bit);
            cyc(CPB);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(which, stop_vals[s]);
            cyc(CPB);
        end
    endtask

    always @(negedge clk) begin
        if (def_ovr) ovr_def++;
        if (par_ovr || o7_ovr) ovr_other++;
    end

    always @(negedge clk) begin
        if (def_valid && rdy_def) begin
            del_def++;
            if (q_def.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL def_unexpected: got word %0h, expected none", def_data);
            end else begin
                e_def = q_def.pop_front();
                chk("def_data", int'(def_data), int'(e_def.data));
                chk("def_perr", int'(def_perr), int'(e_def.perr));
                chk("def_ferr", int'(def_ferr), int'(e_def.ferr));
            end
        end
    end

    always @(negedge clk) begin
        if (par_valid && rdy_par) begin
            if (q_par.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL par_unexpected: got word %0h, expected none", par_data);
            end else begin
                e_par = q_par.pop_front();
                chk("par_data", int'(par_data), int'(e_par.data));
                chk("par_perr", int'(par_perr), int'(e_par.perr));
                chk("par_ferr", int'(par_ferr), int'(e_par.ferr));
            end
        end
    end

    always @(negedge clk) begin
        if (v7_valid && rdy_7) begin
            if (q_7.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u7_unexpected: got word %0h, expected none", d7_data);
            end else begin
                e_7 = q_7.pop_front();
                chk("u7_data", int'(d7_data), int'(e_7.data));
                chk("u7_perr", int'(p7_perr), int'(e_7.perr));
                chk("u7_ferr", int'(f7_ferr), int'(e_7.ferr));
            end
        end
    end

    initial begin
        int lat;
        int d0;
        int o0;
        bit seen;

        rst = 1'b1;
        rx_def = 1'b1; rx_par = 1'b1; rx_7 = 1'b1;
        rdy_def = 1'b1; rdy_par = 1'b1; rdy_7 = 1'b1;
        cyc(5);
        chk("rst_valid", int'(def_valid), 0);
        chk("rst_data", int'(def_data), 0);
        chk("rst_perr", int'(def_perr), 0);
        chk("rst_ferr", int'(def_ferr), 0);
        chk("rst_ovr", int'(def_ovr), 0);
        chk("rst_busy", int'(def_busy), 0);
        rst = 1'b0;
        cyc(10);

        // 8N1 0xA5 with latency measured from the start edge
        push(DEF, 9'h0A5, 1'b0, 1'b0);
        lat = 0;
        seen = 1'b0;
        fork
            send_frame(DEF, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
            begin
                for (int i = 0; i < 2000 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (def_valid) seen = 1'b1;
                end
            end
        join
        n_cmp++;
        if (!seen || lat < 988 || lat > 992) begin
            n_bad++;
            $display("FAIL t1_latency: got %0d cycles (seen=%0d), expected 988..992", lat, seen);
        end
        cyc(50);

        // 8E1 0x37: five ones, so the correct even parity bit is 1
        push(PAR, 9'h037, 1'b1, 1'b0);
        send_frame(PAR, 9'h037, 8, 1'b1, 1'b0, 1, 2'b11);
        cyc(50);
        push(PAR, 9'h037, 1'b0, 1'b0);
        send_frame(PAR, 9'h037, 8, 1'b1, 1'b1, 1, 2'b11);
        cyc(50);

        // held-low line: one flagged word, then recovery
        d0 = del_def;
        push(DEF, 9'h000, 1'b0, 1'b1);
        send_frame(DEF, 9'h000, 8, 1'b0, 1'b0, 1, 2'b00);
        cyc(3000);
        chk("t3_words_in_break", del_def - d0, 1);
        chk("t3_busy_in_break", int'(def_busy), 1);
        rx_def = 1'b1;
        cyc(20);
        chk("t3_busy_after_high", int'(def_busy), 0);
        push(DEF, 9'h03C, 1'b0, 1'b0);
        send_frame(DEF, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11);
        cyc(50);

        // 30-cycle glitch is rejected at the start-bit midpoint
        rx_def = 1'b0;
        cyc(20);
        chk("t4_busy_during", int'(def_busy), 1);
        cyc(10);
        rx_def = 1'b1;
        cyc(30);
        chk("t4_busy_after", int'(def_busy), 0);
        chk("t4_no_valid", int'(def_valid), 0);

        // overrun: second frame dropped while first is held
        rdy_def = 1'b0;
        o0 = ovr_def;
        push(DEF, 9'h011, 1'b0, 1'b0);
        send_frame(DEF, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(DEF, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
        cyc(200);
        chk("t5_overrun_pulses", ovr_def - o0, 1);
        chk("t5_valid_held", int'(def_valid), 1);
        chk("t5_data_held", int'(def_data), 'h11);
        rdy_def = 1'b1;
        cyc(2);
        chk("t5_valid_after_accept", int'(def_valid), 0);

        // reset mid-DATA of 0x5A, then 0xC3
        rx_def = 1'b0; cyc(CPB);
        rx_def = 1'b0; cyc(CPB);
        rx_def = 1'b1; cyc(CPB);
        rx_def = 1'b0; cyc(50);
        chk("t6_busy_mid_frame", int'(def_busy), 1);
        rst = 1'b1;
        cyc(3);
        chk("t6_busy_in_reset", int'(def_busy), 0);
        chk("t6_valid_in_reset", int'(def_valid), 0);
        rx_def = 1'b1;
        rst = 1'b0;
        cyc(20);
        push(DEF, 9'h0C3, 1'b0, 1'b0);
        send_frame(DEF, 9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11);
        cyc(50);

        // 7N2: good frame, bad second stop bit, then recovery
        push(U7, 9'h055, 1'b0, 1'b0);
        send_frame(U7, 9'h055, 7, 1'b0, 1'b0, 2, 2'b11);
        cyc(50);
        push(U7, 9'h02A, 1'b0, 1'b1);
        send_frame(U7, 9'h02A, 7, 1'b0, 1'b0, 2, 2'b01);
        rx_7 = 1'b1;
        cyc(50);
        push(U7, 9'h07F, 1'b0, 1'b0);
        send_frame(U7, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b11);

        for (int i = 0; i < 3000 && (q_def.size() + q_par.size() + q_7.size()) != 0; i++) begin
            cyc(1);
        end
        cyc(20);
        chk("end_def_queue_empty", q_def.size(), 0);
        chk("end_par_queue_empty", q_par.size(), 0);
        chk("end_u7_queue_empty", q_7.size(), 0);
        chk("end_other_overruns", ovr_other, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
